// File: rtl/adat_rx_frame_parser_param.sv
// ADAT receive frame parser: tracks frame position from decoded bit groups,
// extracts user bits and channel words, checks separators, maps S/MUX slots.
module adat_rx_frame_parser_param #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 24,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4:0]            i_bits,
  input  logic [2:0]            i_bit_count,
  input  logic                  i_valid,
  input  logic                  i_sync,
  input  logic [1:0]            i_smux_mode,
  output logic [3:0]            o_user,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CH_W-1:0]       o_channel,
  output logic [CH_W-1:0]       o_audio_ch,
  output logic [1:0]            o_sample_idx,
  output logic                  o_data_valid,
  output logic                  o_frame_done,
  output logic                  o_sep_error,
  output logic                  o_overrun
);

  localparam int NIB       = DATA_WIDTH / 4;
  localparam int FRAME_LEN = 5 + NUM_CHANNELS * NIB * 5;
  localparam int PW        = $clog2(FRAME_LEN + 1);
  localparam int NW        = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [PW-1:0]   LEN_P    = PW'(FRAME_LEN);
  localparam logic [PW-1:0]   USER_END = PW'(5);
  localparam logic [NW-1:0]   NIB_LAST = NW'(NIB - 1);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, USER, DATA, DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [2:0]            bit_q, bit_d;
  logic [NW-1:0]         nib_q, nib_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [3:0]            user_sh_q, user_sh_d;
  logic [3:0]            user_q, user_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       channel_q, channel_d;
  logic [CH_W-1:0]       audio_q, audio_d;
  logic [1:0]            sample_q, sample_d;
  logic                  dv_q, dv_d;
  logic                  fd_q, fd_d;
  logic                  sep_q, sep_d;
  logic                  ovr_q, ovr_d;
  logic                  b;
  logic [2:0]            ch_ext;

  // Walk the group bit by bit so any alignment, including a word boundary
  // inside the group, lands on the correct frame offset.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    bit_d     = bit_q;
    nib_d     = nib_q;
    ch_d      = ch_q;
    word_d    = word_q;
    user_sh_d = user_sh_q;
    user_d    = user_q;
    data_d    = data_q;
    channel_d = channel_q;
    audio_d   = audio_q;
    sample_d  = sample_q;
    dv_d      = 1'b0;
    fd_d      = 1'b0;
    sep_d     = sep_q;
    ovr_d     = ovr_q;
    b         = 1'b0;
    ch_ext    = '0;
    if (!i_sync) begin
      state_d   = IDLE;
      pos_d     = '0;
      bit_d     = '0;
      nib_d     = '0;
      ch_d      = '0;
      word_d    = '0;
      user_sh_d = '0;
      sep_d     = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      if (state_q == IDLE) state_d = USER;
      if (i_valid && i_bit_count != 3'd0 && i_bit_count <= 3'd5) begin
        for (int unsigned i = 0; i < 5; i++) begin
          if (3'(i) < i_bit_count) begin
            b = i_bits[i];
            case (state_d)
              USER: begin
                if (pos_d == '0) begin
                  if (!b) sep_d = 1'b1;
                end else begin
                  user_sh_d[2'(pos_d - PW'(1))] = b;
                end
                pos_d = pos_d + PW'(1);
                if (pos_d == USER_END) begin
                  state_d = DATA;
                  user_d  = user_sh_d;
                end
              end
              DATA: begin
                if (bit_d != 3'd4) begin
                  word_d = {word_d[DATA_WIDTH-2:0], b};
                  bit_d  = bit_d + 3'd1;
                end else begin
                  if (!b) sep_d = 1'b1;
                  bit_d = '0;
                  if (nib_d == NIB_LAST) begin
                    nib_d     = '0;
                    dv_d      = 1'b1;
                    data_d    = word_d;
                    channel_d = ch_d;
                    ch_ext    = 3'(ch_d);
                    case (i_smux_mode)
                      2'd1: begin
                        audio_d  = CH_W'(ch_ext >> 1);
                        sample_d = {1'b0, ch_ext[0]};
                      end
                      2'd2: begin
                        audio_d  = CH_W'(ch_ext >> 2);
                        sample_d = ch_ext[1:0];
                      end
                      default: begin
                        audio_d  = ch_d;
                        sample_d = 2'd0;
                      end
                    endcase
                    if (ch_d == CH_LAST) fd_d = 1'b1;
                    else                 ch_d = ch_d + CH_W'(1);
                  end else begin
                    nib_d = nib_d + NW'(1);
                  end
                end
                pos_d = pos_d + PW'(1);
                if (pos_d == LEN_P) state_d = DONE;
              end
              DONE:    ovr_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      bit_q     <= '0;
      nib_q     <= '0;
      ch_q      <= '0;
      word_q    <= '0;
      user_sh_q <= '0;
      user_q    <= '0;
      data_q    <= '0;
      channel_q <= '0;
      audio_q   <= '0;
      sample_q  <= '0;
      dv_q      <= 1'b0;
      fd_q      <= 1'b0;
      sep_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      bit_q     <= bit_d;
      nib_q     <= nib_d;
      ch_q      <= ch_d;
      word_q    <= word_d;
      user_sh_q <= user_sh_d;
      user_q    <= user_d;
      data_q    <= data_d;
      channel_q <= channel_d;
      audio_q   <= audio_d;
      sample_q  <= sample_d;
      dv_q      <= dv_d;
      fd_q      <= fd_d;
      sep_q     <= sep_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_user       = user_q;
  assign o_data       = data_q;
  assign o_channel    = channel_q;
  assign o_audio_ch   = audio_q;
  assign o_sample_idx = sample_q;
  assign o_data_valid = dv_q;
  assign o_frame_done = fd_q;
  assign o_sep_error  = sep_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_adat_rx_frame_parser_param.sv
// Scoreboard bench for the ADAT frame parser: frames are built as bit vectors,
// sent in groups of various sizes, expected words queued as boundaries pass.
module tb_adat_rx_frame_parser_param;

  localparam int NC  = 8;
  localparam int DW  = 24;
  localparam int NIB = DW / 4;
  localparam int L   = 5 + NC * NIB * 5;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [4:0]    i_bits;
  logic [2:0]    i_bit_count;
  logic          i_valid;
  logic          i_sync;
  logic [1:0]    i_smux_mode;
  logic [3:0]    o_user;
  logic [DW-1:0] o_data;
  logic [2:0]    o_channel;
  logic [2:0]    o_audio_ch;
  logic [1:0]    o_sample_idx;
  logic          o_data_valid;
  logic          o_frame_done;
  logic          o_sep_error;
  logic          o_overrun;

  always #5 i_clk = ~i_clk;

  adat_rx_frame_parser_param #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bits(i_bits), .i_bit_count(i_bit_count),
    .i_valid(i_valid), .i_sync(i_sync), .i_smux_mode(i_smux_mode),
    .o_user(o_user), .o_data(o_data), .o_channel(o_channel),
    .o_audio_ch(o_audio_ch), .o_sample_idx(o_sample_idx),
    .o_data_valid(o_data_valid), .o_frame_done(o_frame_done),
    .o_sep_error(o_sep_error), .o_overrun(o_overrun)
  );

  typedef struct {
    logic [2:0]    ch;
    logic [DW-1:0] data;
    logic [2:0]    ach;
    logic [1:0]    sidx;
    logic          fd;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] words[NC];
  logic [L-1:0]  frame_v;
  int            fb;
  int            mode_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: advance the bit count by one and queue a word at each boundary.
  task automatic model_bit();
    int   k;
    int   m;
    exp_t e;
    fb++;
    if (fb >= 35 && fb <= L && (fb - 5) % 30 == 0) begin
      k = (fb - 5) / 30 - 1;
      m = (mode_m == 3) ? 0 : mode_m;
      e.ch   = 3'(k);
      e.data = words[k];
      e.ach  = (m == 2) ? 3'(k >> 2) : (m == 1) ? 3'(k >> 1) : 3'(k);
      e.sidx = (m == 2) ? 2'(k & 3) : (m == 1) ? 2'(k & 1) : 2'd0;
      e.fd   = (k == NC - 1);
      sb.push_back(e);
    end
  endtask

  task automatic push(input logic [4:0] b, input int c);
    i_bits      = b;
    i_bit_count = 3'(c);
    i_valid     = 1'b1;
    if (c >= 1 && c <= 5)
      for (int i = 0; i < c; i++) model_bit();
    @(posedge i_clk); #1;
    i_valid     = 1'b0;
    i_bits      = '0;
    i_bit_count = '0;
  endtask

  task automatic build_frame(input logic [3:0] user, input int bad_sep);
    frame_v    = '0;
    frame_v[0] = 1'b1;
    for (int u = 0; u < 4; u++) frame_v[1 + u] = user[u];
    for (int c = 0; c < NC; c++) begin
      for (int j = 0; j < DW; j++)
        frame_v[5 + c * 30 + (j / 4) * 5 + (j % 4)] = words[c][DW - 1 - j];
      for (int n = 0; n < NIB; n++) frame_v[5 + c * 30 + n * 5 + 4] = 1'b1;
    end
    if (bad_sep >= 0) frame_v[bad_sep] = 1'b0;
  endtask

  // g = 0 picks a random group size 1..5 per push.
  task automatic send_range(input int from, input int to, input int g);
    int         p;
    int         gg;
    logic [4:0] b;
    p = from;
    while (p < to) begin
      gg = (g == 0) ? int'($urandom_range(1, 5)) : g;
      if (p + gg > to) gg = to - p;
      b = '0;
      for (int i = 0; i < gg; i++) b[i] = frame_v[p + i];
      push(b, gg);
      p += gg;
    end
  endtask

  task automatic restart();
    i_sync = 1'b0;
    @(posedge i_clk); #1;
    i_sync = 1'b1;
    fb = 0;
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge i_clk);
    #1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic randomize_words();
    for (int c = 0; c < NC; c++) words[c] = DW'($urandom());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_user"},   32'(o_user), 32'd0);
    check({tag, "_data"},   32'(o_data), 32'd0);
    check({tag, "_chan"},   32'(o_channel), 32'd0);
    check({tag, "_audio"},  32'(o_audio_ch), 32'd0);
    check({tag, "_sample"}, 32'(o_sample_idx), 32'd0);
    check({tag, "_valid"},  32'(o_data_valid), 32'd0);
    check({tag, "_done"},   32'(o_frame_done), 32'd0);
    check({tag, "_sep"},    32'(o_sep_error), 32'd0);
    check({tag, "_ovr"},    32'(o_overrun), 32'd0);
  endtask

  always @(negedge i_clk) begin
    if (i_rst && o_data_valid) begin
      check("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("data",       32'(o_data), 32'(e.data));
        check("channel",    32'(o_channel), 32'(e.ch));
        check("audio_ch",   32'(o_audio_ch), 32'(e.ach));
        check("sample_idx", 32'(o_sample_idx), 32'(e.sidx));
        check("frame_done", 32'(o_frame_done), 32'(e.fd));
      end
    end else if (i_rst && o_frame_done) begin
      check("done_with_valid", 32'(o_data_valid), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b0; i_sync = 1'b0; i_valid = 1'b0; i_bits = '0;
    i_bit_count = '0; i_smux_mode = 2'd0; mode_m = 0; fb = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Aligned: user push then channel 0 = 24'h123456 in 5-bit groups
    i_sync = 1'b1;
    push(5'b10101, 5);
    check("user_first", 32'(o_user), 32'h0000_000a);
    randomize_words();
    words[0] = 24'h123456;
    build_frame(4'b1010, -1);
    send_range(5, 35, 5);
    drain("aligned_pending");
    check("aligned_sep", 32'(o_sep_error), 32'd0);
    restart();

    // Straddle: 3-bit groups, plus ignored groups of count 0 and 6
    randomize_words();
    words[0] = 24'h123456;
    build_frame(4'b0110, -1);
    send_range(0, 6, 3);
    check("user_straddle", 32'(o_user), 32'h0000_0006);
    send_range(6, 100, 3);
    push(5'b11111, 0);
    push(5'b00000, 6);
    send_range(100, L, 3);
    drain("straddle_pending");
    check("straddle_ovr", 32'(o_overrun), 32'd0);
    check("straddle_sep", 32'(o_sep_error), 32'd0);
    restart();

    // Full frame of all-ones words, then one extra group
    for (int c = 0; c < NC; c++) words[c] = '1;
    build_frame(4'b1111, -1);
    send_range(0, L, 5);
    drain("full_pending");
    check("full_ovr_before", 32'(o_overrun), 32'd0);
    push(5'b11111, 5);
    check("full_ovr_after", 32'(o_overrun), 32'd1);
    drain("full_no_extra");
    restart();
    check("ovr_cleared", 32'(o_overrun), 32'd0);
    check("user_held", 32'(o_user), 32'h0000_000f);

    // Separator error in channel 2, nibble 0
    randomize_words();
    build_frame(4'b1001, 5 + 2 * 30 + 4);
    send_range(0, L, 4);
    drain("sep_pending");
    check("sep_set", 32'(o_sep_error), 32'd1);
    restart();
    check("sep_cleared", 32'(o_sep_error), 32'd0);

    // S/MUX4, S/MUX2 and mode 3 with random group sizes
    for (int m = 2; m >= 1; m--) begin
      mode_m = m; i_smux_mode = 2'(m);
      randomize_words();
      build_frame(4'(m), -1);
      send_range(0, L, 0);
      drain("smux_pending");
      restart();
    end
    mode_m = 3; i_smux_mode = 2'd3;
    randomize_words();
    build_frame(4'b0011, -1);
    send_range(0, 130, 0);
    drain("mode3_pending");
    restart();

    // Async reset mid-frame
    mode_m = 2; i_smux_mode = 2'd2;
    randomize_words();
    build_frame(4'b1100, -1);
    send_range(0, 50, 5);
    drain("prereset_pending");
    check("prereset_user", 32'(o_user), 32'h0000_000c);
    #2 i_rst = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    i_sync = 1'b0;
    fb = 0;
    @(posedge i_clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
